// File: rtl/execute_if.sv
// ----------------------------------------------------------------------------
// execute_if -- bundle between the execute stage and its neighbours.
//
// Signals (direction as seen by the execute stage, modport slave):
//   IR, PC, A, B, I   in  32  instruction, PC, rs1, rs2, immediate from read
//   v_in              in   1  upstream valid
//   r_in              in   1  downstream ready
//   stall             in   1  hazard-unit stall
//   r_out             out  1  ready to upstream (combinational)
//   v_out             out  1  result valid to downstream (registered)
//   IR_out, PC_out    out 32  registered instruction / PC
//   RES_out           out 32  ALU result, effective address or link address
//   B_out             out 32  registered rs2 (store data)
//   br_taken          out  1  one-cycle redirect pulse
//   br_target         out 32  redirect address, valid while br_taken=1
// The master modport is the environment side (read stage + memory stage).
// ----------------------------------------------------------------------------
interface execute_if;
    logic [31:0] IR;
    logic [31:0] PC;
    logic [31:0] A;
    logic [31:0] B;
    logic [31:0] I;
    logic        v_in;
    logic        r_in;
    logic        stall;
    logic        r_out;
    logic        v_out;
    logic [31:0] IR_out;
    logic [31:0] PC_out;
    logic [31:0] RES_out;
    logic [31:0] B_out;
    logic        br_taken;
    logic [31:0] br_target;

    modport master (
        output IR, PC, A, B, I, v_in, r_in, stall,
        input  r_out, v_out, IR_out, PC_out, RES_out, B_out, br_taken, br_target
    );

    modport slave (
        input  IR, PC, A, B, I, v_in, r_in, stall,
        output r_out, v_out, IR_out, PC_out, RES_out, B_out, br_taken, br_target
    );
endinterface

// File: rtl/execute.sv
// ----------------------------------------------------------------------------
// execute -- RV32I pipeline execute stage.
//
// Computes the ALU result, load/store effective address, link address and
// branch/jump decision for the instruction presented by the read stage and
// registers it towards the memory stage with a valid/ready/stall handshake.
// Shifts by a non-zero amount use a bit-serial shifter (one bit per cycle),
// keeping the stage busy (r_out=0) until the shift completes.
//
// Ports:
//   clk  in   pipeline clock, rising edge
//   rst  in   synchronous active-high reset
//   bus  execute_if.slave  operands in, registered results out (see execute_if)
// ----------------------------------------------------------------------------
module execute (
    input  logic      clk,
    input  logic      rst,
    execute_if.slave  bus
);
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_REG    = 7'b0110011;

    typedef enum logic [0:0] {
        ST_IDLE  = 1'b0,
        ST_SHIFT = 1'b1
    } state_t;

    // Branch condition selected by funct3; unknown encodings never take.
    function automatic logic branch_cond(input logic [2:0] f3,
                                         input logic [31:0] a,
                                         input logic [31:0] b);
        logic c;
        case (f3)
            3'b000:  c = (a == b);
            3'b001:  c = (a != b);
            3'b100:  c = ($signed(a) <  $signed(b));
            3'b101:  c = ($signed(a) >= $signed(b));
            3'b110:  c = (a <  b);
            3'b111:  c = (a >= b);
            default: c = 1'b0;
        endcase
        return c;
    endfunction

    // One step of the serial shifter; arithmetic right shift replicates bit 31.
    function automatic logic [31:0] shift_one(input logic [31:0] v,
                                              input logic        left,
                                              input logic        arith);
        logic [31:0] r;
        if (left) begin
            r = {v[30:0], 1'b0};
        end else begin
            r = {arith & v[31], v[31:1]};
        end
        return r;
    endfunction

    state_t      state_r;
    state_t      state_next_s;
    logic [31:0] acc_r;
    logic [4:0]  cnt_r;
    logic        shl_r;
    logic        sra_r;

    logic        v_out_r;
    logic [31:0] ir_out_r;
    logic [31:0] pc_out_r;
    logic [31:0] res_out_r;
    logic [31:0] b_out_r;
    logic        br_taken_r;
    logic [31:0] br_target_r;

    logic [6:0]  opcode_s;
    logic [2:0]  funct3_s;
    logic        alt_s;
    logic [31:0] op2_s;
    logic [4:0]  shamt_s;
    logic        is_shift_s;
    logic [31:0] res_s;
    logic        taken_s;
    logic [31:0] target_s;
    logic [31:0] acc_step_s;

    logic        r_out_s;
    logic        accept_s;
    logic        start_shift_s;
    logic        shift_step_s;
    logic        shift_done_s;

    assign opcode_s = bus.IR[6:0];
    assign funct3_s = bus.IR[14:12];
    assign alt_s    = bus.IR[30];

    // Operand selection and shift classification for the ALU opcodes.
    always_comb begin
        op2_s      = (opcode_s == OP_REG) ? bus.B : bus.I;
        shamt_s    = op2_s[4:0];
        if ((opcode_s == OP_IMM) || (opcode_s == OP_REG)) begin
            is_shift_s = (funct3_s == 3'b001) || (funct3_s == 3'b101);
        end else begin
            is_shift_s = 1'b0;
        end
        acc_step_s = shift_one(acc_r, shl_r, sra_r);
    end

    // Single-cycle result, branch decision and redirect target by opcode.
    always_comb begin
        res_s    = 32'h0000_0000;
        taken_s  = 1'b0;
        target_s = 32'h0000_0000;
        case (opcode_s)
            OP_LUI:   res_s = bus.I;
            OP_AUIPC: res_s = bus.PC + bus.I;
            OP_JAL: begin
                res_s    = bus.PC + 32'd4;
                target_s = bus.PC + bus.I;
                taken_s  = 1'b1;
            end
            OP_JALR: begin
                res_s    = bus.PC + 32'd4;
                target_s = (bus.A + bus.I) & ~32'd1;
                taken_s  = 1'b1;
            end
            OP_BRANCH: begin
                target_s = bus.PC + bus.I;
                taken_s  = branch_cond(funct3_s, bus.A, bus.B);
            end
            OP_LOAD, OP_STORE: res_s = bus.A + bus.I;
            OP_IMM, OP_REG: begin
                case (funct3_s)
                    3'b000: begin
                        if ((opcode_s == OP_REG) && alt_s) begin
                            res_s = bus.A - op2_s;
                        end else begin
                            res_s = bus.A + op2_s;
                        end
                    end
                    3'b010:  res_s = {31'd0, ($signed(bus.A) < $signed(op2_s))};
                    3'b011:  res_s = {31'd0, (bus.A < op2_s)};
                    3'b100:  res_s = bus.A ^ op2_s;
                    3'b110:  res_s = bus.A | op2_s;
                    3'b111:  res_s = bus.A & op2_s;
                    // Shift by zero finishes here; non-zero amounts go serial.
                    3'b001, 3'b101: res_s = bus.A;
                    default: res_s = 32'h0000_0000;
                endcase
            end
            default: res_s = 32'h0000_0000;
        endcase
    end

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_next_s;
        end
    end

    // Next-state logic: IDLE <-> SHIFT.
    always_comb begin
        state_next_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (start_shift_s) begin
                    state_next_s = ST_SHIFT;
                end else begin
                    state_next_s = ST_IDLE;
                end
            end
            ST_SHIFT: begin
                if (shift_done_s) begin
                    state_next_s = ST_IDLE;
                end else begin
                    state_next_s = ST_SHIFT;
                end
            end
            default: state_next_s = ST_IDLE;
        endcase
    end

    // Handshake and shifter control decoded from the current state.
    always_comb begin
        r_out_s       = ~rst & (state_r == ST_IDLE) & ~bus.stall & (bus.r_in | ~v_out_r);
        accept_s      = bus.v_in & r_out_s;
        start_shift_s = accept_s & is_shift_s & (shamt_s != 5'd0);
        shift_step_s  = (state_r == ST_SHIFT) & ~bus.stall;
        shift_done_s  = shift_step_s & (cnt_r == 5'd1);
    end

    // Result registers, serial shifter and branch pulse.
    always_ff @(posedge clk) begin
        if (rst) begin
            v_out_r     <= 1'b0;
            ir_out_r    <= 32'h0000_0000;
            pc_out_r    <= 32'h0000_0000;
            res_out_r   <= 32'h0000_0000;
            b_out_r     <= 32'h0000_0000;
            br_taken_r  <= 1'b0;
            br_target_r <= 32'h0000_0000;
            acc_r       <= 32'h0000_0000;
            cnt_r       <= 5'd0;
            shl_r       <= 1'b0;
            sra_r       <= 1'b0;
        end else if (accept_s) begin
            ir_out_r <= bus.IR;
            pc_out_r <= bus.PC;
            b_out_r  <= bus.B;
            if (start_shift_s) begin
                // Result not ready yet: the previous one was taken this edge.
                v_out_r    <= 1'b0;
                br_taken_r <= 1'b0;
                acc_r      <= bus.A;
                cnt_r      <= shamt_s;
                shl_r      <= (funct3_s == 3'b001);
                sra_r      <= alt_s;
            end else begin
                v_out_r     <= 1'b1;
                res_out_r   <= res_s;
                br_taken_r  <= taken_s;
                br_target_r <= target_s;
            end
        end else if (shift_done_s) begin
            res_out_r  <= acc_step_s;
            v_out_r    <= 1'b1;
            br_taken_r <= 1'b0;
        end else begin
            br_taken_r <= 1'b0;
            if (shift_step_s) begin
                acc_r <= acc_step_s;
                cnt_r <= cnt_r - 5'd1;
            end
            // In IDLE a stall or a downstream take retires the current result.
            if ((state_r == ST_IDLE) && (bus.stall || bus.r_in)) begin
                v_out_r <= 1'b0;
            end
        end
    end

    assign bus.r_out     = r_out_s;
    assign bus.v_out     = v_out_r;
    assign bus.IR_out    = ir_out_r;
    assign bus.PC_out    = pc_out_r;
    assign bus.RES_out   = res_out_r;
    assign bus.B_out     = b_out_r;
    assign bus.br_taken  = br_taken_r;
    assign bus.br_target = br_target_r;
endmodule

// File: tb/tb_execute.sv
// ----------------------------------------------------------------------------
// tb_execute -- scoreboard bench for the execute stage. Stimulus pushes the
// hand-computed expected result when an instruction is accepted; a monitor
// pops and compares each time a fresh result appears on v_out.
// ----------------------------------------------------------------------------
module tb_execute;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_REG    = 7'b0110011;

    typedef struct {
        logic [31:0] ir;
        logic [31:0] pc;
        logic [31:0] res;
        logic [31:0] b;
        logic        taken;
        logic [31:0] target;
    } exp_t;

    logic clk;
    logic rst;
    int   checks;
    int   errors;
    exp_t sb_q[$];

    execute_if bus();

    execute dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    // Free-running clock, period 10.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Hard time limit so the run always terminates.
    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic logic [31:0] mk(input logic [6:0] op, input logic [2:0] f3,
                                       input logic alt);
        logic [31:0] r;
        r        = 32'h0000_0000;
        r[6:0]   = op;
        r[14:12] = f3;
        r[30]    = alt;
        return r;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks = checks + 1;
        if (act !== exp) begin
            errors = errors + 1;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Present one instruction; push its expected result at the accepting edge.
    task automatic issue(input logic [31:0] ir, input logic [31:0] pc,
                         input logic [31:0] a, input logic [31:0] b, input logic [31:0] imm,
                         input logic [31:0] res, input logic taken,
                         input logic [31:0] target, input logic push);
        exp_t e;
        int   tries;
        logic done;
        bus.IR = ir; bus.PC = pc; bus.A = a; bus.B = b; bus.I = imm;
        bus.v_in = 1'b1;
        tries = 0;
        done  = 1'b0;
        while (!done && tries < 50) begin
            @(negedge clk);
            if (bus.r_out) begin
                if (push) begin
                    e.ir = ir; e.pc = pc; e.res = res; e.b = b;
                    e.taken = taken; e.target = target;
                    sb_q.push_back(e);
                end
                done = 1'b1;
            end else begin
                tries = tries + 1;
            end
            @(posedge clk);
            #1;
        end
        bus.v_in = 1'b0;
        chk("accept_tries", tries, 32'd0);
    endtask

    // Count cycles until the shift result appears, optionally stalling.
    task automatic wait_result(input int exp_lat, input int stall_from, input int stall_len);
        int   k;
        logic seen;
        k    = 0;
        seen = 1'b0;
        while (!seen && k < 100) begin
            @(negedge clk);
            if (bus.v_out) begin
                seen = 1'b1;
            end else begin
                chk("busy_r_out", {31'd0, bus.r_out}, 32'd0);
                @(posedge clk);
                #1;
                bus.stall = (k >= stall_from) && (k < stall_from + stall_len);
                k = k + 1;
            end
        end
        bus.stall = 1'b0;
        chk("shift_latency", k, exp_lat);
        @(posedge clk);
        #1;
    endtask

    // Monitor: compare each fresh result against the scoreboard, check
    // br_taken is a single-cycle pulse and outputs hold under backpressure.
    initial begin
        exp_t        e;
        logic        prev_v;
        logic        prev_r;
        logic [31:0] prev_res;
        logic [31:0] prev_pc;
        logic        fresh;
        prev_v = 1'b0; prev_r = 1'b0; prev_res = 32'h0; prev_pc = 32'h0;
        forever begin
            @(negedge clk);
            if (!rst) begin
                fresh = bus.v_out && (!prev_v || prev_r);
                if (fresh) begin
                    if (sb_q.size() == 0) begin
                        chk("unexpected_result", {31'd0, bus.v_out}, 32'd0);
                    end else begin
                        e = sb_q.pop_front();
                        chk("RES_out", bus.RES_out, e.res);
                        chk("IR_out", bus.IR_out, e.ir);
                        chk("PC_out", bus.PC_out, e.pc);
                        chk("B_out", bus.B_out, e.b);
                        chk("br_taken", {31'd0, bus.br_taken}, {31'd0, e.taken});
                        if (e.taken) begin
                            chk("br_target", bus.br_target, e.target);
                        end
                    end
                end else begin
                    chk("br_taken_pulse", {31'd0, bus.br_taken}, 32'd0);
                    if (prev_v && !prev_r && bus.v_out) begin
                        chk("hold_RES_out", bus.RES_out, prev_res);
                        chk("hold_PC_out", bus.PC_out, prev_pc);
                    end
                end
            end
            prev_v   = bus.v_out;
            prev_r   = bus.r_in;
            prev_res = bus.RES_out;
            prev_pc  = bus.PC_out;
        end
    end

    // Directed stimulus.
    initial begin
        checks = 0;
        errors = 0;
        rst = 1'b1;
        bus.IR = 32'h0; bus.PC = 32'h0; bus.A = 32'h0; bus.B = 32'h0; bus.I = 32'h0;
        bus.v_in = 1'b0; bus.r_in = 1'b1; bus.stall = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;

        // Reset state
        @(negedge clk);
        chk("rst_v_out", {31'd0, bus.v_out}, 32'd0);
        chk("rst_br_taken", {31'd0, bus.br_taken}, 32'd0);
        chk("rst_RES_out", bus.RES_out, 32'h0);
        chk("rst_IR_out", bus.IR_out, 32'h0);
        chk("rst_PC_out", bus.PC_out, 32'h0);
        chk("rst_B_out", bus.B_out, 32'h0);
        chk("rst_br_target", bus.br_target, 32'h0);
        chk("rst_r_out", {31'd0, bus.r_out}, 32'd1);
        @(posedge clk);
        #1;

        // Back-to-back single-cycle operations
        issue(mk(OP_IMM, 3'b000, 1'b0), 32'h10, 32'd7, 32'd0, 32'd5, 32'd12, 1'b0, 32'h0, 1'b1);
        issue(mk(OP_REG, 3'b000, 1'b1), 32'h14, 32'd3, 32'd5, 32'd0, 32'hFFFF_FFFE, 1'b0, 32'h0, 1'b1);
        issue(mk(OP_BRANCH, 3'b100, 1'b0), 32'h100, 32'hFFFF_FFFF, 32'd1, 32'h20, 32'h0, 1'b1, 32'h120, 1'b1);
        issue(mk(OP_BRANCH, 3'b110, 1'b0), 32'h100, 32'hFFFF_FFFF, 32'd1, 32'h20, 32'h0, 1'b0, 32'h0, 1'b1);
        issue(mk(OP_JALR, 3'b000, 1'b0), 32'h200, 32'h1003, 32'd0, 32'd4, 32'h204, 1'b1, 32'h1006, 1'b1);
        issue(mk(OP_JAL, 3'b000, 1'b0), 32'h300, 32'd0, 32'd0, 32'h10, 32'h304, 1'b1, 32'h310, 1'b1);
        issue(mk(OP_LUI, 3'b000, 1'b0), 32'h304, 32'd0, 32'd0, 32'h1234_5000, 32'h1234_5000, 1'b0, 32'h0, 1'b1);
        issue(mk(OP_AUIPC, 3'b000, 1'b0), 32'h1000, 32'd0, 32'd0, 32'h2000, 32'h3000, 1'b0, 32'h0, 1'b1);
        issue(mk(OP_LOAD, 3'b010, 1'b0), 32'h1004, 32'h100, 32'hDEAD_BEEF, 32'd8, 32'h108, 1'b0, 32'h0, 1'b1);
        issue(mk(OP_STORE, 3'b010, 1'b0), 32'h1008, 32'h200, 32'hCAFE_F00D, 32'hFFFF_FFFC, 32'h1FC, 1'b0, 32'h0, 1'b1);
        issue(mk(OP_REG, 3'b100, 1'b0), 32'h20, 32'hF0F0_F0F0, 32'hFF00_FF00, 32'd0, 32'h0FF0_0FF0, 1'b0, 32'h0, 1'b1);
        issue(mk(OP_REG, 3'b110, 1'b0), 32'h24, 32'hF0F0_F0F0, 32'hFF00_FF00, 32'd0, 32'hFFF0_FFF0, 1'b0, 32'h0, 1'b1);
        issue(mk(OP_REG, 3'b111, 1'b0), 32'h28, 32'hF0F0_F0F0, 32'hFF00_FF00, 32'd0, 32'hF000_F000, 1'b0, 32'h0, 1'b1);
        issue(mk(OP_IMM, 3'b010, 1'b0), 32'h2C, 32'hFFFF_FFFE, 32'd0, 32'd1, 32'd1, 1'b0, 32'h0, 1'b1);
        issue(mk(OP_IMM, 3'b011, 1'b0), 32'h30, 32'hFFFF_FFFE, 32'd0, 32'd1, 32'd0, 1'b0, 32'h0, 1'b1);
        issue(mk(OP_BRANCH, 3'b000, 1'b0), 32'h400, 32'd5, 32'd5, 32'hFFFF_FFF0, 32'h0, 1'b1, 32'h3F0, 1'b1);
        issue(mk(OP_BRANCH, 3'b001, 1'b0), 32'h404, 32'd5, 32'd5, 32'h8, 32'h0, 1'b0, 32'h0, 1'b1);
        issue(mk(OP_BRANCH, 3'b101, 1'b0), 32'h500, 32'd1, 32'hFFFF_FFFF, 32'h8, 32'h0, 1'b1, 32'h508, 1'b1);
        issue(mk(OP_BRANCH, 3'b111, 1'b0), 32'h504, 32'd1, 32'hFFFF_FFFF, 32'h8, 32'h0, 1'b0, 32'h0, 1'b1);
        issue(32'h0000_007F, 32'h600, 32'h55, 32'h66, 32'h77, 32'h0, 1'b0, 32'h0, 1'b1);

        // Serial shifts
        issue(mk(OP_REG, 3'b101, 1'b1), 32'h700, 32'h8000_0000, 32'd4, 32'd0, 32'hF800_0000, 1'b0, 32'h0, 1'b1);
        wait_result(4, 100, 0);
        issue(mk(OP_IMM, 3'b001, 1'b0), 32'h704, 32'h5, 32'd0, 32'd0, 32'h5, 1'b0, 32'h0, 1'b1);
        wait_result(0, 100, 0);
        issue(mk(OP_IMM, 3'b101, 1'b0), 32'h708, 32'h8000_0001, 32'd0, 32'd1, 32'h4000_0000, 1'b0, 32'h0, 1'b1);
        wait_result(1, 100, 0);
        issue(mk(OP_IMM, 3'b101, 1'b1), 32'h70C, 32'h8000_0001, 32'd0, 32'h401, 32'hC000_0000, 1'b0, 32'h0, 1'b1);
        wait_result(1, 100, 0);
        issue(mk(OP_REG, 3'b001, 1'b0), 32'h710, 32'h1, 32'd3, 32'd0, 32'h8, 1'b0, 32'h0, 1'b1);
        wait_result(3, 100, 0);
        // SRL by 8 with a two-cycle stall in the middle
        issue(mk(OP_REG, 3'b101, 1'b0), 32'h714, 32'hF000_0000, 32'd8, 32'd0, 32'h00F0_0000, 1'b0, 32'h0, 1'b1);
        wait_result(10, 1, 2);

        // Backpressure: result held for 3 cycles, then taken
        @(posedge clk);
        #1;
        bus.r_in = 1'b0;
        issue(mk(OP_REG, 3'b000, 1'b0), 32'h800, 32'd100, 32'd23, 32'd0, 32'd123, 1'b0, 32'h0, 1'b1);
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            chk("hold_v_out", {31'd0, bus.v_out}, 32'd1);
            chk("hold_r_out", {31'd0, bus.r_out}, 32'd0);
            @(posedge clk);
            #1;
        end
        bus.r_in = 1'b1;
        @(negedge clk);
        chk("release_v_out", {31'd0, bus.v_out}, 32'd1);
        chk("release_RES_out", bus.RES_out, 32'd123);
        @(posedge clk);
        #1;

        // Reset on the 3rd cycle of an SLL by 10
        issue(mk(OP_REG, 3'b001, 1'b0), 32'h900, 32'h1, 32'd10, 32'd0, 32'h400, 1'b0, 32'h0, 1'b0);
        @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        chk("abort_v_out", {31'd0, bus.v_out}, 32'd0);
        chk("abort_r_out", {31'd0, bus.r_out}, 32'd1);
        chk("abort_RES_out", bus.RES_out, 32'h0);
        chk("abort_IR_out", bus.IR_out, 32'h0);
        chk("abort_PC_out", bus.PC_out, 32'h0);
        chk("abort_B_out", bus.B_out, 32'h0);
        for (int c = 0; c < 15; c++) begin
            @(negedge clk);
            chk("no_late_result", {31'd0, bus.v_out}, 32'd0);
        end

        repeat (3) @(posedge clk);
        #1;
        chk("scoreboard_empty", sb_q.size(), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/execute.md
# execute

Pipeline execute stage of the RISC-V RV32I core. Sits directly downstream of the register read stage and consumes its instruction, PC, operand A/B and immediate outputs. Computes the ALU result, load/store effective address, link address and branch/jump decision, then hands the result to the memory stage through the same valid/ready/stall discipline used by the other stages. Shifts run on a bit-serial shifter: one bit per cycle, which holds the stage busy for shamt cycles.

## Interface
- No parameters; widths fixed at 32-bit data, 5-bit shift count. Opcode and funct3 encodings come from `definitions.v`.
- clk  in  1  pipeline clock; all state changes on the rising edge.
- rst  in  1  synchronous, active-high reset.
- IR  in  32  instruction from the read stage.
- PC  in  32  instruction address.
- A  in  32  rs1 value.
- B  in  32  rs2 value.
- I  in  32  decoded immediate.
- v_in  in  1  upstream valid.
- r_in  in  1  downstream ready.
- stall  in  1  hazard-unit stall.
- r_out  out  1  ready to upstream (combinational).
- v_out  out  1  result valid to downstream (registered).
- IR_out  out  32  registered instruction.
- PC_out  out  32  registered PC.
- RES_out  out  32  ALU result, effective address, or link address.
- B_out  out  32  registered rs2, used as store data.
- br_taken  out  1  one-cycle redirect pulse to fetch.
- br_target  out  32  redirect address, valid while br_taken=1.

## Operation
- Ready and accept:
  - r_out = ~rst & state==IDLE & ~stall & (r_in | ~v_out).
  - accept = v_in & r_out.
- Results by opcode, registered on accept:
  - LUI: RES = I.
  - AUIPC: RES = PC+I.
  - JAL: RES = PC+4; target = PC+I; taken.
  - JALR: RES = PC+4; target = (A+I) & ~1; taken.
  - BRANCH: target = PC+I; RES = 0. Funct3 selects BEQ, BNE, BLT, BGE (signed compare) or BLTU, BGEU (unsigned compare); taken when the condition holds.
  - LOAD/STORE: RES = A+I; B_out = B.
  - IM_ALU/REG_ALU: op2 = I for IM_ALU, B for REG_ALU.
    - ADD, or SUB when REG_ALU & IR[30].
    - SLT, SLTU, XOR, OR, AND.
    - SLL; SR as SRA when IR[30]=1, otherwise SRL.
  - Any other opcode: RES = 0, not taken; still passed through with v_out.
- All arithmetic is modulo 2^32; overflow is ignored.
- Shifts: shamt = op2[4:0].
  - shamt=0: completes in a single cycle with RES=A.
  - shamt>0: on accept, state goes to SHIFT with acc=A and cnt=shamt.
  - Each non-stalled SHIFT edge: acc shifts 1 bit (SRA replicates bit 31), cnt decrements.
  - On the edge where cnt==1, the shifted value goes to RES_out, v_out<=1, and state returns to IDLE.
- State machine: IDLE ↔ SHIFT only.
- Output hold: while v_out=1 & r_in=0, all outputs hold and nothing is accepted.
- stall:
  - IDLE: next edge forces v_out<=0; data outputs hold.
  - SHIFT: freezes acc and cnt.
- br_taken is asserted only on the edge its instruction's result registers. It is cleared on the following edge even if the output is held. The fetch and read stages squash younger instructions themselves.

## Timing
- Reset values: v_out=0, br_taken=0, state=IDLE. IR_out, PC_out, RES_out, B_out and br_target are all 0.
- Reset mid-shift aborts the shift with no output.
- Reset has priority over stall; stall has priority over accept.
- Non-shift latency: accept at edge N → v_out=1 after edge N.
- Shift by k≥1: accept at edge N → v_out=1 after edge N+k.
  - r_out=0 during edges N+1..N+k.
  - Each stalled cycle extends this by one.
- Back-to-back: a new instruction can be accepted on the same edge the previous result is taken (r_in=1), giving 1 instruction/cycle with no bubble for non-shift ops.
- r_out is not registered. The upstream stage samples it at the same edge it presents v_in.

## Test plan
- ADDI, A=7, I=5, v_in=1, r_in=1 → after 1 edge: v_out=1, RES_out=12, br_taken=0. SUB (REG_ALU, IR[30]=1), A=3, B=5 → RES_out=0xFFFFFFFE.
- BLT with A=0xFFFFFFFF, B=1, PC=0x100, I=0x20 → br_taken=1 for exactly one cycle, br_target=0x120. Same operands as BLTU → br_taken=0.
- JALR with A=0x1003, I=4, PC=0x200 → RES_out=0x204, br_target=0x1006, br_taken=1.
- SRA, A=0x80000000, B=4 → r_out=0 for 4 cycles, then v_out=1 with RES_out=0xF8000000. SLLI with shamt=0, A=0x5 → RES_out=0x5 after 1 edge.
- Backpressure and stall:
  - r_in=0 while v_out=1 → outputs hold and r_out=0 for 3 cycles; result is unchanged when r_in returns.
  - stall=1 during an SRL by 8 for 2 cycles → completion is delayed by exactly 2 cycles.
- rst pulsed on the 3rd cycle of an SLL by 10 → next edge: v_out=0, r_out=1, all outputs 0, and no late result appears.
